// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine
//   Streams an IMG_H x IMG_W unsigned image in raster order and produces the
//   3x3 convolution with a signed kernel loaded in front of each job. The
//   convolution is "valid" only (no padding), with optional stride 2, and an
//   optional ReLU before saturation to OUT_W bits.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start, cfg_stride2,        job start (IDLE only); configuration is
//   cfg_relu                   captured together with start
//   k_valid/k_ready/k_data     9 kernel coefficients, raster order
//   pix_valid/pix_ready/       image pixels, row-major
//   pix_data
//   res_valid/res_ready/       convolution results; res_last flags the final
//   res_data/res_last          result of the job
//   busy, done                 job in progress / one-cycle end-of-job pulse
//   cycles_out                 STREAM cycles spent by the most recent job
//   state_dbg                  current FSM state (debug visibility)
//
// Handshakes: a transfer happens on every clock edge where valid && ready.
// A producer holds valid and data stable until the transfer; ready may be
// driven combinationally and never waits on valid.

module conv2d_stream_engine #(
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 10,
    parameter int PIX_W  = 4,
    parameter int COEF_W = 5,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cfg_stride2,
    input  logic                     cfg_relu,
    input  logic                     k_valid,
    output logic                     k_ready,
    input  logic [COEF_W-1:0]        k_data,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [OUT_W-1:0]  res_data,
    output logic                     res_last,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              cycles_out,
    output logic [1:0]               state_dbg
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int SUM_W = PIX_W + COEF_W + 5;
    localparam int EW    = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    // Position of the final stride-2 result: largest index with (idx-2) even.
    localparam int LAST_R2 = (((IMG_H - 3) % 2) == 0) ? IMG_H - 1 : IMG_H - 2;
    localparam int LAST_C2 = (((IMG_W - 3) % 2) == 0) ? IMG_W - 1 : IMG_W - 2;

    localparam logic signed [EW-1:0] MAX_E = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] MIN_E = EW'(-(64'sd1 <<< (OUT_W - 1)));

    logic [1:0]               state;
    logic [3:0]               k_cnt;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     all_in;
    logic                     stride2_q;
    logic                     relu_q;

    logic signed [COEF_W-1:0] coef [9];
    logic [PIX_W-1:0]         lb0 [IMG_W];   // row r-1
    logic [PIX_W-1:0]         lb1 [IMG_W];   // row r-2
    logic [PIX_W-1:0]         win [3][3];    // [row r-2..r][col c-2..c]
    logic [PIX_W-1:0]         nwin [3][3];

    logic                     k_acc;
    logic                     pix_acc;
    logic                     produce;
    logic                     is_last;
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  relu_v;
    logic signed [EW-1:0]     ext;
    logic signed [EW-1:0]     sat_v;

    assign state_dbg = state;
    assign busy      = (state == S_LOAD) || (state == S_STREAM);
    assign done      = (state == S_DONE);
    assign k_ready   = (state == S_LOAD);
    assign pix_ready = (state == S_STREAM) && !all_in && (!res_valid || res_ready);
    assign k_acc     = k_valid && k_ready;
    assign pix_acc   = pix_valid && pix_ready;

    // With stride 2, (r-2) even is the same as r even.
    assign produce = (row >= RW'(2)) && (col >= CW'(2)) &&
                     (!stride2_q || (!row[0] && !col[0]));
    assign is_last = stride2_q ? ((row == RW'(LAST_R2)) && (col == CW'(LAST_C2)))
                               : ((row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1)));

    // Window as it will look once the incoming pixel is shifted in; the result
    // is computed from it so it can be registered on the accept edge.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nwin[i][0] = win[i][1];
            nwin[i][1] = win[i][2];
        end
        nwin[0][2] = lb1[col];
        nwin[1][2] = lb0[col];
        nwin[2][2] = pix_data;
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = acc + $signed({{(SUM_W - PIX_W){1'b0}}, nwin[i][j]}) *
                            SUM_W'(coef[i * 3 + j]);
            end
        end
        relu_v = (relu_q && (acc < 0)) ? '0 : acc;
        ext    = EW'(relu_v);
        if (ext > MAX_E) begin
            sat_v = MAX_E;
        end else if (ext < MIN_E) begin
            sat_v = MIN_E;
        end else begin
            sat_v = ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k_cnt      <= '0;
            row        <= '0;
            col        <= '0;
            all_in     <= 1'b0;
            stride2_q  <= 1'b0;
            relu_q     <= 1'b0;
            res_valid  <= 1'b0;
            res_last   <= 1'b0;
            res_data   <= '0;
            cycles_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        k_cnt     <= '0;
                        stride2_q <= cfg_stride2;
                        relu_q    <= cfg_relu;
                    end
                end
                S_LOAD: begin
                    if (k_acc) begin
                        k_cnt <= k_cnt + 4'd1;
                        if (k_cnt == 4'd8) begin
                            state      <= S_STREAM;
                            cycles_out <= '0;
                            row        <= '0;
                            col        <= '0;
                            all_in     <= 1'b0;
                        end
                    end
                end
                S_STREAM: begin
                    cycles_out <= cycles_out + 16'd1;
                    if (res_valid && res_ready && res_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (pix_acc) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + RW'(1);
                    if (row == RW'(IMG_H - 1)) begin
                        all_in <= 1'b1;
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end

            if (pix_acc && produce) begin
                res_valid <= 1'b1;
                res_data  <= OUT_W'(sat_v);
                res_last  <= is_last;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Storage below is never cleared: every window read for a result was
    // written earlier in the same job, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (rst_n && k_acc) begin
            coef[k_cnt] <= k_data;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_data;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= nwin[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
module tb_conv2d_stream_engine;

    localparam int IMG_W  = 12;
    localparam int IMG_H  = 10;
    localparam int PIX_W  = 4;
    localparam int COEF_W = 5;
    localparam int NPIX   = IMG_W * IMG_H;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst_n, start, cfg_stride2, cfg_relu, k_valid, pix_valid, res_ready;
    logic [COEF_W-1:0] k_data;
    logic [PIX_W-1:0]  pix_data;

    logic               k_ready, pix_ready, res_valid, res_last, busy, done;
    logic signed [15:0] res_data;
    logic [15:0]        cycles_out;
    logic [1:0]         state_dbg;

    logic               k_ready_8, pix_ready_8, res_valid_8, res_last_8, busy_8, done_8;
    logic signed [7:0]  res_data_8;
    logic [15:0]        cycles_out_8;
    logic [1:0]         state_dbg_8;

    always #5 clk = ~clk;

    conv2d_stream_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W),
                           .COEF_W(COEF_W), .OUT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_stride2(cfg_stride2),
        .cfg_relu(cfg_relu), .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .done(done), .cycles_out(cycles_out),
        .state_dbg(state_dbg)
    );

    conv2d_stream_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W),
                           .COEF_W(COEF_W), .OUT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_stride2(cfg_stride2),
        .cfg_relu(cfg_relu), .k_valid(k_valid), .k_ready(k_ready_8), .k_data(k_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready_8), .pix_data(pix_data),
        .res_valid(res_valid_8), .res_ready(res_ready), .res_data(res_data_8),
        .res_last(res_last_8), .busy(busy_8), .done(done_8), .cycles_out(cycles_out_8),
        .state_dbg(state_dbg_8)
    );

    // ---------------- vector table ----------------
    // pix_val < 0 selects a ramp image, coef_val == -99 selects coefs i-4.
    typedef struct {
        int pix_val;
        int coef_val;
        bit s2;
        bit relu;
        int exp_cnt;
        int exp_cyc;
        bit use_const;
        int c16;
        int c8;
    } vec_t;

    vec_t vecs [7];

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [7:0]  exp8_q[$];
    int img  [NPIX];
    int coef [9];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    task automatic fill(input vec_t v);
        for (int p = 0; p < NPIX; p++) begin
            img[p] = (v.pix_val >= 0) ? v.pix_val : (((p / IMG_W) * 3 + (p % IMG_W) * 5) % 16);
        end
        for (int i = 0; i < 9; i++) begin
            coef[i] = (v.coef_val == -99) ? i - 4 : v.coef_val;
        end
    endtask

    task automatic build_expected(input vec_t v);
        int s;
        exp_q.delete();
        exp8_q.delete();
        for (int r = 2; r < IMG_H; r++) begin
            for (int c = 2; c < IMG_W; c++) begin
                if (v.s2 && ((((r - 2) % 2) != 0) || (((c - 2) % 2) != 0))) continue;
                if (v.use_const) begin
                    exp_q.push_back(16'(v.c16));
                    exp8_q.push_back(8'(v.c8));
                end else begin
                    s = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            s += img[(r - 2 + i) * IMG_W + (c - 2 + j)] * coef[i * 3 + j];
                    if (v.relu && s < 0) s = 0;
                    exp_q.push_back(16'(sat(s, 16)));
                    exp8_q.push_back(8'(sat(s, 8)));
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_k_ready"}, k_ready, 0);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_last"}, res_last, 0);
        check({tag, "_cycles_out"}, cycles_out, 0);
        check({tag, "_state"}, state_dbg, 0);
        check({tag, "_8_idle"}, {busy_8, done_8, k_ready_8, pix_ready_8,
                                 res_valid_8, res_last_8, state_dbg_8}, 0);
        check({tag, "_8_cycles_out"}, cycles_out_8, 0);
    endtask

    // ---------------- driver ----------------
    // Entered and left at posedge+1. Inputs change right after a posedge;
    // handshakes are evaluated 1 time unit later, before the next edge.
    task automatic run_job(input vec_t v, input bit stall, input int abort_after);
        int k_i, p_i, n_res, n_done, stall_left, post, guard;
        bit fin;
        logic [15:0] held, e16;
        logic [7:0]  e8;
        build_expected(v);
        // k/pix traffic in IDLE must be ignored
        start = 1; cfg_stride2 = v.s2; cfg_relu = v.relu;
        k_valid = 1; k_data = 5'h07; pix_valid = 1; pix_data = 4'hF; res_ready = 1;
        @(posedge clk); #1;
        // config changes after start must not matter
        cfg_stride2 = ~v.s2; cfg_relu = ~v.relu;
        k_i = 0; p_i = 0; n_res = 0; n_done = 0; stall_left = 5; post = 0; guard = 0;
        held = '0; fin = 0;
        while (!fin) begin
            start = (n_done == 0);   // ignored while busy
            k_valid = 1;
            k_data = (k_i < 9) ? COEF_W'(coef[k_i]) : 5'h07;
            pix_valid = (p_i < NPIX) && (abort_after < 0 || p_i < abort_after);
            pix_data = pix_valid ? PIX_W'(img[p_i]) : 4'hF;
            res_ready = !(stall && res_valid && n_res == 2 && stall_left > 0);
            #1;
            if (done) n_done++;
            if (!res_ready) begin
                if (stall_left == 5) held = res_data;
                else check("stall_hold", res_data, held);
                check("stall_pix_ready", pix_ready, 0);
                stall_left--;
            end
            if (k_valid && k_ready && k_i < 9) k_i++;
            if (pix_valid && pix_ready) p_i++;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("res_extra", n_res, -1);
                end else begin
                    e16 = exp_q.pop_front();
                    e8  = exp8_q.pop_front();
                    check("res16", int'(res_data), int'($signed(e16)));
                    check("res8", int'(res_data_8), int'($signed(e8)));
                    check("res8_valid", res_valid_8, 1);
                    check("res_last", res_last, (n_res == v.exp_cnt - 1) ? 1 : 0);
                    check("res_last8", res_last_8, (n_res == v.exp_cnt - 1) ? 1 : 0);
                    if (stall && n_res == 2) check("stall_value", res_data, held);
                end
                n_res++;
            end
            if (n_done > 0) post++;
            if (post == 3) fin = 1;
            if (abort_after >= 0 && p_i >= abort_after) fin = 1;
            guard++;
            if (guard >= 3000) begin
                check("timeout", guard, -1);
                fin = 1;
            end
            @(posedge clk); #1;
        end
        start = 0;
        if (abort_after < 0) begin
            check("result_count", n_res, v.exp_cnt);
            check("done_pulses", n_done, 1);
            check("cycles_out", cycles_out, v.exp_cyc + (stall ? 5 : 0));
            check("cycles_out8", cycles_out_8, v.exp_cyc + (stall ? 5 : 0));
            check("busy_after", busy, 0);
        end
    endtask

    task automatic abort_and_reset();
        int bad;
        rst_n = 0; start = 0; pix_valid = 1; res_ready = 1;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst_n = 1;
        exp_q.delete();
        exp8_q.delete();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            k_valid = 1; pix_valid = 1; res_ready = 1;
            #1;
            if (res_valid || pix_ready || k_ready || busy) bad++;
            @(posedge clk); #1;
        end
        check("post_abort_quiet", bad, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{1, 1, 0, 0, 80, 121, 1, 9, 9};
        vecs[1] = '{1, 1, 1, 0, 20, 108, 1, 9, 9};
        vecs[2] = '{15, -1, 0, 0, 80, 121, 1, -135, -128};
        vecs[3] = '{15, -1, 0, 1, 80, 121, 1, 0, 0};
        vecs[4] = '{15, 15, 0, 0, 80, 121, 1, 2025, 127};
        vecs[5] = '{-1, -99, 0, 0, 80, 121, 0, 0, 0};
        vecs[6] = '{-1, -99, 1, 1, 20, 108, 0, 0, 0};

        rst_n = 0; start = 0; cfg_stride2 = 0; cfg_relu = 0;
        k_valid = 0; k_data = '0; pix_valid = 0; pix_data = '0; res_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            fill(vecs[i]);
            run_job(vecs[i], 1'b0, -1);
        end

        // backpressure on the 3rd result
        fill(vecs[0]);
        run_job(vecs[0], 1'b1, -1);

        // abort after 50 pixels, then a clean job
        fill(vecs[5]);
        run_job(vecs[5], 1'b0, 50);
        abort_and_reset();
        fill(vecs[0]);
        run_job(vecs[0], 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv2d_stream_engine.md
CONV2D_STREAM_ENGINE -- requirements
Module: conv2d_stream_engine

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameters (name, default, meaning), one per line:
- IMG_W, 12, image columns, >=3
- IMG_H, 10, image rows, >=3
- PIX_W, 4, unsigned pixel width
- COEF_W, 5, signed two's-complement coefficient width
- OUT_W, 16, signed result width
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst_n, in, 1, sync active-low reset
- start, in, 1, begin job; sampled in IDLE only
- cfg_stride2, in, 1, 1 = stride 2; sampled with start
- cfg_relu, in, 1, 1 = clamp negative results to 0; sampled with start
- k_valid / k_ready, in / out, 1 / 1, coefficient handshake
- k_data, in, COEF_W, coefficient in raster order (k0 = top-left)
- pix_valid / pix_ready, in / out, 1 / 1, pixel handshake
- pix_data, in, PIX_W, pixel in raster order (row-major)
- res_valid / res_ready, out / in, 1 / 1, result handshake
- res_data, out, OUT_W, signed result
- res_last, out, 1, final result of the job
- busy, out, 1, high in LOAD_KERNEL or STREAM
- done, out, 1, one-cycle pulse at job end
- cycles_out, out, 16, STREAM-state cycle count of the last job

Function
REQ-004 States SHALL be IDLE, LOAD_KERNEL, STREAM and DONE, with these transitions:
- IDLE to LOAD_KERNEL on start
- LOAD_KERNEL to STREAM after the 9th k handshake
- STREAM to DONE on the res_last handshake
- DONE to IDLE after exactly 1 cycle
REQ-005 k_ready SHALL be high only in LOAD_KERNEL; each coefficient SHALL be stored on a k_valid & k_ready cycle.
REQ-006 pix_ready SHALL be asserted exactly when state==STREAM, all IMG_W*IMG_H pixels are not yet accepted, and (!res_valid || res_ready).
REQ-007 The pixel stream SHALL be held in 2 line buffers of IMG_W entries plus a 3x3 window; pixel position (r,c) SHALL be tracked by wrap counters (c wraps at IMG_W-1, r increments on wrap).
REQ-008 A result SHALL be produced for accepted pixel (r,c) when r>=2 and c>=2 and, if stride2, (r-2) and (c-2) are both even; its window is rows r-2..r, cols c-2..c.
REQ-009 Latency: res_valid SHALL rise in the cycle after the producing pixel's accept; res_data and res_last SHALL hold stable while res_valid && !res_ready.
REQ-010 The sum SHALL be the exact signed sum of 9 products (unsigned pixel × signed coefficient), computed at width PIX_W+COEF_W+5.
REQ-011 The sum SHALL then be ReLU-clamped if cfg_relu, then saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-012 Result count SHALL be (IMG_H-2)*(IMG_W-2) for stride 1, else ceil((IMG_H-2)/2)*ceil((IMG_W-2)/2); res_last SHALL mark the final one.
REQ-013 Line buffers and the window SHALL NOT need clearing between jobs; no result may depend on a pixel from a previous job.
REQ-014 start SHALL be ignored outside IDLE; k_valid outside LOAD_KERNEL and pix_valid outside STREAM SHALL be ignored.
REQ-015 cycles_out SHALL be cleared on entry to STREAM, incremented every STREAM cycle including the exit cycle, and held until the next STREAM entry.
REQ-016 busy SHALL be combinational from state; done SHALL be high exactly when state==DONE.

Reset
REQ-017 On rst_n low at a clk edge:
- state SHALL go to IDLE
- res_valid, res_last, done, busy, k_ready, pix_ready and cycles_out SHALL become 0
- position counters and coefficient count SHALL clear
REQ-018 Reset mid-job SHALL abort with no further results; the next job SHALL behave identically to one run after power-up.

Verification
REQ-019 Defaults, all pixels 1, all coefs 1, stride 1, ready always high -> 80 results of 9, res_last on the 80th, cycles_out=121, one done pulse.
REQ-020 Same image with cfg_stride2=1 -> 20 results of 9 (rows 2,4,6,8; cols 2,4,6,8,10).
REQ-021 All pixels 15, all coefs -1 (5'h1F): relu=0 -> each result -135; relu=1 -> each result 0.
REQ-022 OUT_W=8, all pixels 15, all coefs 15 -> each result 127 (saturated from 2025).
REQ-023 Hold res_ready low 5 cycles at the 3rd result -> pix_ready low, res_data stable, no result lost or duplicated, cycles_out grows by 5.
REQ-024 rst_n low for 1 cycle after 50 pixels, then a full job -> output identical to REQ-019.
